// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-to-1 arbitrating mux with a one-entry
// output register and round-robin or fixed-priority selection.
module rr_arb_mux #(
  parameter int N     = 16,
  parameter int WIDTH = 8,
  parameter int RR    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  output logic [N-1:0]              in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N)-1:0]      out_sel,
  input  logic                      out_ready
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] ptr_nxt;
  logic          have_req;
  logic          take;
  logic          load;
  int            idx;

  // Scan channels starting at ptr, wrapping modulo N.
  always_comb begin
    grant    = '0;
    have_req = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!have_req && in_valid[SW'(idx)]) begin
        have_req = 1'b1;
        grant    = SW'(idx);
      end
    end
  end

  assign take = !out_valid || out_ready;
  assign load = take && have_req;

  assign ptr_nxt = (grant == SW'(N - 1)) ? '0
                 : grant + 1'b1;

  always_comb begin
    in_ready = '0;
    if (!reset && load) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant];
      out_sel   <= grant;
      if (RR != 0) ptr <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert ($onehot0(in_ready));
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: round-robin and
// fixed-priority instances driven with directed vectors.
module tb_rr_arb_mux;

  localparam int N = 16;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [3:0]        out_sel;
  logic              out_ready;

  logic              f_reset;
  logic [N-1:0]      f_in_valid;
  logic [N-1:0][W-1:0] f_in_data;
  logic [N-1:0]      f_in_ready;
  logic              f_out_valid;
  logic [W-1:0]      f_out_data;
  logic [3:0]        f_out_sel;
  logic              f_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];

  always #5 clk = ~clk;

  rr_arb_mux #(.N(N), .WIDTH(W), .RR(1)) u0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.N(N), .WIDTH(W), .RR(0)) u1 (
    .clk       (clk),
    .reset     (f_reset),
    .in_valid  (f_in_valid),
    .in_data   (f_in_data),
    .in_ready  (f_in_ready),
    .out_valid (f_out_valid),
    .out_data  (f_out_data),
    .out_sel   (f_out_sel),
    .out_ready (f_out_ready)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Output monitors: pop one expected word per output transfer.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb0_extra: got %0h expected none",
                 {out_sel, out_data});
      end else begin
        chk("sb0_word", {20'd0, out_sel, out_data},
            {20'd0, q0.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (f_out_valid && f_out_ready) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb1_extra: got %0h expected none",
                 {f_out_sel, f_out_data});
      end else begin
        chk("sb1_word", {20'd0, f_out_sel, f_out_data},
            {20'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    reset       = 1'b1;
    in_valid    = '1;
    in_data     = '0;
    out_ready   = 1'b1;
    f_reset     = 1'b1;
    f_in_valid  = '0;
    f_in_data   = '0;
    f_out_ready = 1'b1;

    // Reset: no acceptance while reset is high
    step();
    at_neg();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    step();

    // Single request on channel 5
    reset       = 1'b0;
    in_valid    = 16'h0020;
    in_data[5]  = 8'hA5;
    at_neg();
    chk("rst_state_valid", 32'(out_valid), 0);
    chk("rst_state_data", 32'(out_data), 0);
    chk("rst_state_sel", 32'(out_sel), 0);
    chk("rst_state_ptr", 32'(u0.ptr), 0);
    chk("single_in_ready", 32'(in_ready), 32'h0020);
    q0.push_back({4'd5, 8'hA5});
    step();
    in_valid = '0;
    at_neg();
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_ptr", 32'(u0.ptr), 6);

    // Fairness: all channels, 32 loads from ptr=0
    step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = W'(i);
    step();
    reset    = 1'b0;
    in_valid = '1;
    for (int c = 0; c < 32; c++) begin
      if (c != 0) step();
      at_neg();
      chk("rr_in_ready", 32'(in_ready),
          32'(16'h1 << (c % 16)));
      if (c != 0) chk("rr_no_bubble", 32'(out_valid), 1);
      q0.push_back({4'(c % 16), 8'(c % 16)});
    end
    step();
    in_valid = '0;
    at_neg();
    chk("rr_last_valid", 32'(out_valid), 1);
    chk("rr_ptr_end", 32'(u0.ptr), 0);
    step();
    at_neg();
    chk("rr_drained", 32'(out_valid), 0);

    // Wrap-around: ptr=14, channels 15 and 1
    step();
    in_valid    = 16'h2000;
    in_data[13] = 8'hD3;
    at_neg();
    chk("wrap_pre_ready", 32'(in_ready), 32'h2000);
    q0.push_back({4'd13, 8'hD3});
    step();
    in_valid    = 16'h8002;
    in_data[15] = 8'hF5;
    in_data[1]  = 8'h1B;
    at_neg();
    chk("wrap_ptr14", 32'(u0.ptr), 14);
    chk("wrap_g15", 32'(in_ready), 32'h8000);
    q0.push_back({4'd15, 8'hF5});
    step();
    in_valid = 16'h0002;
    at_neg();
    chk("wrap_ptr0", 32'(u0.ptr), 0);
    chk("wrap_g1", 32'(in_ready), 32'h0002);
    q0.push_back({4'd1, 8'h1B});
    step();
    in_valid = '0;
    at_neg();
    chk("wrap_ptr2", 32'(u0.ptr), 2);

    // Backpressure with a word from channel 0 held
    step();
    in_valid   = 16'h0001;
    in_data[0] = 8'h0C;
    at_neg();
    chk("bp_load0", 32'(in_ready), 32'h0001);
    q0.push_back({4'd0, 8'h0C});
    step();
    out_ready  = 1'b0;
    in_valid   = 16'h0088;
    in_data[3] = 8'h33;
    in_data[7] = 8'h77;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) step();
      at_neg();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h0C);
      chk("bp_sel", 32'(out_sel), 0);
    end
    step();
    out_ready = 1'b1;
    at_neg();
    chk("bp_ptr", 32'(u0.ptr), 1);
    chk("bp_release_g3", 32'(in_ready), 32'h0008);
    q0.push_back({4'd3, 8'h33});
    step();
    in_valid = 16'h0080;
    at_neg();
    chk("bp_then_g7", 32'(in_ready), 32'h0080);
    q0.push_back({4'd7, 8'h77});
    step();
    in_valid = '0;

    // Reset mid-stream with a held word and ptr=9
    step();
    in_valid   = 16'h0100;
    in_data[8] = 8'h8E;
    at_neg();
    chk("mid_load8", 32'(in_ready), 32'h0100);
    step();
    in_valid  = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    at_neg();
    chk("mid_held", 32'(out_valid), 1);
    chk("mid_ptr9", 32'(u0.ptr), 9);
    chk("mid_rst_ready", 32'(in_ready), 0);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    at_neg();
    chk("mid_valid0", 32'(out_valid), 0);
    chk("mid_data0", 32'(out_data), 0);
    chk("mid_sel0", 32'(out_sel), 0);
    chk("mid_ptr0", 32'(u0.ptr), 0);

    // Fixed priority: channels 2 and 9 both requesting
    step();
    f_reset      = 1'b0;
    f_in_valid   = 16'h0204;
    f_in_data[2] = 8'h22;
    f_in_data[9] = 8'h99;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) step();
      at_neg();
      chk("fp_g2", 32'(f_in_ready), 32'h0004);
      q1.push_back({4'd2, 8'h22});
    end
    step();
    f_in_valid = 16'h0200;
    at_neg();
    chk("fp_g9", 32'(f_in_ready), 32'h0200);
    chk("fp_ptr", 32'(u1.ptr), 0);
    q1.push_back({4'd9, 8'h99});
    step();
    f_in_valid = '0;

    step();
    step();
    at_neg();
    chk("sb0_empty", q0.size(), 0);
    chk("sb1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Registered N-to-1 arbitrating multiplexer with per-channel valid/ready handshakes. It generalises the combinational fixed-select muxes: the block selects one requesting channel per cycle using round-robin or fixed-priority arbitration. It holds the winning word in a one-entry output register. The output side is a valid/ready stream for downstream consumers such as shared buses and FIFOs. Upstream producers deliver data on the per-channel inputs.

## Interface
- N, default 16: number of input channels; N ≥ 2.
- WIDTH, default 8: data width per channel.
- RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with the lowest index winning.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  [N-1:0]  per-channel request.
- in_data  input  [N-1:0][WIDTH-1:0]  per-channel data.
- in_ready  output  [N-1:0]  per-channel accept; at most one bit is high.
- out_valid  output  1  output register holds a word.
- out_data  output  [WIDTH-1:0]  held word.
- out_sel  output  [$clog2(N)-1:0]  source channel index of the held word.
- out_ready  input  1  downstream accept.

## Operation
- Round-robin priority pointer `ptr`, width $clog2(N):
  - Priority order is ptr, ptr+1, … N-1, 0, … ptr-1, with wrap-around modulo N.
  - In fixed-priority mode (RR=0), ptr is held at 0.
- Grant `g`:
  - g is the first index with in_valid high, taken in priority order.
  - g is computed combinationally each cycle.
  - If no channel is requesting, there is no grant.
- `load` = (!out_valid || out_ready) && (any in_valid).
- in_ready[g] = !out_valid || out_ready. Every other in_ready bit is 0.
  - in_ready depends combinationally on in_valid and out_ready.
  - Producers must not derive in_valid from in_ready.
- On load:
  - out_data ← in_data[g].
  - out_sel ← g.
  - out_valid ← 1.
  - When RR=1, ptr ← (g+1) mod N. For N not a power of 2, g = N-1 wraps ptr to 0.
- When out_valid && out_ready && !load: out_valid ← 0. out_data and out_sel hold their last value.
- When out_valid && !out_ready: the register and ptr hold. All in_ready bits are 0 (backpressure).
- When no channel is requesting, ptr is unchanged.
- Handshakes:
  - An input transfer occurs when in_valid[i] && in_ready[i].
  - An output transfer occurs when out_valid && out_ready.
  - A producer keeps in_valid and in_data stable until its transfer completes. The grant may still move to a higher-priority channel that asserts in_valid in the meantime. Nothing is accepted until in_ready is high.
- Reset, including mid-operation:
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - Any held word is discarded.
  - in_ready is all 0 during the reset cycle.

## Timing
- Latency: a word accepted in cycle t appears on out_* in cycle t+1.
- Throughput is one word per cycle when out_ready is held high. Simultaneous output drain and input load in the same cycle are supported with no bubble.
- out_valid, out_data and out_sel are driven directly from flops.
- in_ready is combinational from in_valid, out_valid and out_ready.
- Fairness with RR=1: with all N channels continuously requesting, each channel is granted exactly once in every N consecutive loads.
- The first cycle after reset deasserts sees ptr=0, so channel 0 has highest priority.

## Test plan
- Reset then single request:
  - Stimulus: reset 2 cycles, then in_valid=16'h0020, in_data[5]=8'hA5, out_ready=1.
  - Required: in_ready=16'h0020 that cycle. The next cycle shows out_valid=1, out_data=8'hA5, out_sel=5, and ptr=6.
- Round-robin fairness:
  - Stimulus: in_valid=16'hFFFF held, in_data[i]=i, out_ready=1 for 32 cycles.
  - Required: out_sel sequence 0,1,…,15,0,…,15, with no bubbles.
- Wrap-around:
  - Stimulus: ptr=14, with channels 15 and 1 requesting.
  - Required: grants 15, then 1, with ptr becoming 0 then 2.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0 for 5 cycles while channels 3 and 7 request.
  - Required: in_ready=0 throughout, and out_data/out_sel stable. When out_ready=1, channel 3 is loaded the same cycle (ptr ≤ 3).
- Fixed priority (RR=0):
  - Stimulus: channels 2 and 9 continuously requesting.
  - Required: channel 2 is granted every cycle. Channel 9 is granted only after channel 2 drops in_valid.
- Reset mid-stream:
  - Stimulus: assert reset while out_valid=1, ptr=9.
  - Required: the next cycle shows out_valid=0, out_data=0, out_sel=0, ptr=0. The held word is never presented.
